// File: rtl/config_chain_loader.sv
// Configuration chain loader: clears a serial DFFR chain, shifts CHAIN_LEN bitstream bits
// into it with a generated programming clock and releases the fabric on a fault-free load.
module config_chain_loader #(
  parameter int unsigned CHAIN_LEN = 64,
  parameter int unsigned CLR_CYC   = 2,
  localparam int unsigned BW = $clog2(CHAIN_LEN + 1)
) (
  input  logic          i_ck,
  input  logic          i_rstn,
  input  logic          i_start,
  input  logic          i_abort,
  input  logic [7:0]    i_in_data,
  input  logic          i_in_valid,
  output logic          o_in_ready,
  output logic          o_prog_ck,
  output logic          o_prog_d,
  output logic          o_prog_rst,
  input  logic          i_prog_q,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_err,
  output logic          o_fabric_en,
  output logic [BW-1:0] o_bits_left
);

  localparam int unsigned CW = (CLR_CYC > 1) ? $clog2(CLR_CYC) : 1;
  localparam logic [CW-1:0] ClrLast = CW'(CLR_CYC - 1);
  localparam logic [BW-1:0] LenW    = BW'(CHAIN_LEN);

  typedef enum logic [2:0] {StIdle, StClear, StFetch, StShiftLo, StShiftHi, StDone} state_e;

  state_e          r_state, w_state_d;
  logic [CW-1:0]   r_clr_cnt, w_clr_cnt_d;
  logic [7:0]      r_sreg, w_sreg_d;
  logic [2:0]      r_idx, w_idx_d;
  logic [BW-1:0]   r_bits_left, w_bits_left_d;
  logic            r_err, w_err_d;
  logic            r_prog_d, w_prog_d_d;
  logic            r_prog_ck, r_prog_rst, r_in_ready, r_busy, r_done, r_fabric_en;

  always_comb begin
    w_state_d     = r_state;
    w_clr_cnt_d   = r_clr_cnt;
    w_sreg_d      = r_sreg;
    w_idx_d       = r_idx;
    w_bits_left_d = r_bits_left;
    w_err_d       = r_err;
    w_prog_d_d    = r_prog_d;
    // Abort outranks START and any pending byte transfer.
    if (i_abort) begin
      w_state_d = StIdle;
    end else begin
      case (r_state)
        StIdle, StDone: begin
          if (i_start) begin
            w_state_d     = StClear;
            w_clr_cnt_d   = '0;
            w_bits_left_d = LenW;
            w_err_d       = 1'b0;
          end
        end
        StClear: begin
          if (r_clr_cnt == ClrLast) w_state_d = StFetch;
          else                      w_clr_cnt_d = r_clr_cnt + CW'(1);
        end
        StFetch: begin
          if (i_in_valid && r_in_ready) begin
            w_state_d  = StShiftLo;
            w_sreg_d   = i_in_data;
            w_idx_d    = 3'd7;
            w_prog_d_d = i_in_data[7];
          end
        end
        StShiftLo: begin
          // Tail must still read the cleared value while the first CHAIN_LEN bits go in.
          if (i_prog_q) w_err_d = 1'b1;
          w_state_d = StShiftHi;
        end
        StShiftHi: begin
          w_bits_left_d = r_bits_left - BW'(1);
          if (r_bits_left == BW'(1)) begin
            w_state_d = StDone;
          end else if (r_idx == 3'd0) begin
            w_state_d = StFetch;
          end else begin
            w_state_d  = StShiftLo;
            w_idx_d    = r_idx - 3'd1;
            w_sreg_d   = {r_sreg[6:0], 1'b0};
            w_prog_d_d = r_sreg[6];
          end
        end
        default: w_state_d = StIdle;
      endcase
    end
    if (w_state_d == StIdle) w_prog_d_d = 1'b0;
  end

  always_ff @(posedge i_ck or negedge i_rstn) begin
    if (!i_rstn) begin
      r_state     <= StIdle;
      r_clr_cnt   <= '0;
      r_sreg      <= '0;
      r_idx       <= '0;
      r_bits_left <= '0;
      r_err       <= 1'b0;
      r_prog_d    <= 1'b0;
      r_prog_ck   <= 1'b0;
      r_prog_rst  <= 1'b1;
      r_in_ready  <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_fabric_en <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_clr_cnt   <= w_clr_cnt_d;
      r_sreg      <= w_sreg_d;
      r_idx       <= w_idx_d;
      r_bits_left <= w_bits_left_d;
      r_err       <= w_err_d;
      r_prog_d    <= w_prog_d_d;
      r_prog_ck   <= (w_state_d == StShiftHi);
      r_prog_rst  <= (w_state_d == StIdle) || (w_state_d == StClear);
      r_in_ready  <= (w_state_d == StFetch);
      r_busy      <= (w_state_d == StClear) || (w_state_d == StFetch) ||
                     (w_state_d == StShiftLo) || (w_state_d == StShiftHi);
      r_done      <= (w_state_d == StDone);
      r_fabric_en <= (w_state_d == StDone) && !w_err_d;
    end
  end

  assign o_in_ready  = r_in_ready;
  assign o_prog_ck   = r_prog_ck;
  assign o_prog_d    = r_prog_d;
  assign o_prog_rst  = r_prog_rst;
  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_err       = r_err;
  assign o_fabric_en = r_fabric_en;
  assign o_bits_left = r_bits_left;

endmodule

// File: tb/tb_config_chain_loader.sv
// Directed bench for config_chain_loader: 12-bit and 64-bit chains with behavioural chain models.
module tb_config_chain_loader;

  logic clk = 1'b0;
  logic rstn = 1'b1;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // 12-bit chain instance
  logic       start12 = 0, abort12 = 0, valid12 = 0, stuck12 = 0;
  logic [7:0] data12 = 0;
  logic       ready12, pck12, pd12, prst12, pq12, busy12, done12, err12, fab12;
  logic [3:0] left12;
  logic [11:0] chain12, seq12;
  int         rise12, rst_edge12, bi12;
  logic [7:0] bytes12 [2] = '{8'hA5, 8'h3C};

  // 64-bit chain instance
  logic       start64 = 0, abort64 = 0, valid64 = 0;
  logic [7:0] data64 = 0;
  logic       ready64, pck64, pd64, prst64, pq64, busy64, done64, err64, fab64;
  logic [6:0] left64;
  logic [63:0] chain64, seq64;
  int         rise64;
  logic [7:0] bytes64 [8] = '{8'hA5, 8'h3C, 8'hF0, 8'h0F, 8'h96, 8'h69, 8'hC3, 8'h81};

  config_chain_loader #(.CHAIN_LEN(12), .CLR_CYC(2)) u_dut12 (
    .i_ck(clk), .i_rstn(rstn), .i_start(start12), .i_abort(abort12), .i_in_data(data12),
    .i_in_valid(valid12), .o_in_ready(ready12), .o_prog_ck(pck12), .o_prog_d(pd12),
    .o_prog_rst(prst12), .i_prog_q(pq12), .o_busy(busy12), .o_done(done12), .o_err(err12),
    .o_fabric_en(fab12), .o_bits_left(left12)
  );

  config_chain_loader #(.CHAIN_LEN(64), .CLR_CYC(2)) u_dut64 (
    .i_ck(clk), .i_rstn(rstn), .i_start(start64), .i_abort(abort64), .i_in_data(data64),
    .i_in_valid(valid64), .o_in_ready(ready64), .o_prog_ck(pck64), .o_prog_d(pd64),
    .o_prog_rst(prst64), .i_prog_q(pq64), .o_busy(busy64), .o_done(done64), .o_err(err64),
    .o_fabric_en(fab64), .o_bits_left(left64)
  );

  // Behavioural DFFR chains: head is bit 0, tail is the MSB.
  always @(posedge pck12 or posedge prst12)
    if (prst12) chain12 <= '0;
    else        chain12 <= {chain12[10:0], pd12};
  assign pq12 = stuck12 ? 1'b1 : chain12[11];

  always @(posedge pck64 or posedge prst64)
    if (prst64) chain64 <= '0;
    else        chain64 <= {chain64[62:0], pd64};
  assign pq64 = chain64[63];

  always @(posedge pck12) begin
    rise12 = rise12 + 1;
    seq12  = {seq12[10:0], pd12};
    if (prst12) rst_edge12 = rst_edge12 + 1;
  end

  always @(posedge pck64) begin
    rise64 = rise64 + 1;
    seq64  = {seq64[62:0], pd64};
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic start_load12;
    rise12 = 0;
    seq12  = '0;
    bi12   = 0;
    data12 = bytes12[0];
    valid12 = 1'b1;
    start12 = 1'b1;
    tick();
    start12 = 1'b0;
  endtask

  // Feed bytes until DONE, or until the SHIFT_HI of bit stop_rise when stop_rise is nonzero.
  task automatic feed12(input int stop_rise, input int max_cyc);
    logic xfer;
    int   n;
    for (n = 0; n < max_cyc; n++) begin
      if (stop_rise != 0 && pck12 && rise12 == stop_rise) break;
      if (stop_rise == 0 && done12) break;
      xfer = valid12 && ready12;
      tick();
      if (xfer) begin
        bi12++;
        data12 = (bi12 < 2) ? bytes12[bi12] : 8'h00;
      end
    end
    total++;
    if (n >= max_cyc) begin
      bad++;
      $display("FAIL feed12_timeout: waited %0d cycles, limit %0d", n, max_cyc);
    end
  endtask

  task automatic test_reset;
    rstn = 1'b0;
    #2;
    total++; if (pck12 !== 1'b0)   begin bad++; $display("FAIL rst_prog_ck: got %b want 0", pck12); end
    total++; if (pd12 !== 1'b0)    begin bad++; $display("FAIL rst_prog_d: got %b want 0", pd12); end
    total++; if (prst12 !== 1'b1)  begin bad++; $display("FAIL rst_prog_rst: got %b want 1", prst12); end
    total++; if (ready12 !== 1'b0) begin bad++; $display("FAIL rst_in_ready: got %b want 0", ready12); end
    total++; if ({busy12, done12, err12, fab12} !== 4'b0000)
      begin bad++; $display("FAIL rst_flags: got %b want 0000", {busy12, done12, err12, fab12}); end
    total++; if (left12 !== 4'd0)  begin bad++; $display("FAIL rst_bits_left: got %0d want 0", left12); end
    tick();
    rstn = 1'b1;
    tick();
  endtask

  task automatic test_basic;
    start_load12();
    feed12(0, 100);
    total++; if (rise12 !== 12) begin bad++; $display("FAIL basic_rises: got %0d want 12", rise12); end
    total++; if (seq12 !== 12'hA53) begin bad++; $display("FAIL basic_seq: got %h want a53", seq12); end
    total++; if (chain12 !== 12'hA53) begin bad++; $display("FAIL basic_chain: got %h want a53", chain12); end
    total++; if ({done12, fab12, err12, busy12} !== 4'b1100)
      begin bad++; $display("FAIL basic_flags: got %b want 1100", {done12, fab12, err12, busy12}); end
    total++; if (bi12 !== 2) begin bad++; $display("FAIL basic_xfers: got %0d want 2", bi12); end
    total++; if (left12 !== 4'd0) begin bad++; $display("FAIL basic_left: got %0d want 0", left12); end
    total++; if (prst12 !== 1'b0) begin bad++; $display("FAIL basic_prog_rst: got %b want 0", prst12); end
    valid12 = 1'b0;
  endtask

  task automatic test_fault;
    stuck12 = 1'b1;
    start_load12();
    total++; if (err12 !== 1'b0) begin bad++; $display("FAIL fault_err_clear: got %b want 0", err12); end
    feed12(1, 50);
    total++; if (err12 !== 1'b1) begin bad++; $display("FAIL fault_err_first: got %b want 1", err12); end
    feed12(0, 100);
    total++; if ({done12, fab12, err12} !== 3'b101)
      begin bad++; $display("FAIL fault_done: got %b want 101", {done12, fab12, err12}); end
    total++; if (rise12 !== 12) begin bad++; $display("FAIL fault_rises: got %0d want 12", rise12); end
    stuck12 = 1'b0;
    start_load12();
    total++; if (err12 !== 1'b0) begin bad++; $display("FAIL fault_restart_err: got %b want 0", err12); end
    feed12(0, 100);
    total++; if ({done12, fab12, err12} !== 3'b110)
      begin bad++; $display("FAIL fault_reload: got %b want 110", {done12, fab12, err12}); end
    valid12 = 1'b0;
  endtask

  task automatic test_abort;
    start_load12();
    feed12(5, 100);
    abort12 = 1'b1;
    start12 = 1'b1;
    tick();
    abort12 = 1'b0;
    start12 = 1'b0;
    total++; if ({pck12, prst12, busy12, done12, ready12, fab12} !== 6'b010000)
      begin bad++; $display("FAIL abort_state: got %b want 010000",
                            {pck12, prst12, busy12, done12, ready12, fab12}); end
    tick();
    total++; if ({busy12, prst12, pck12} !== 3'b010)
      begin bad++; $display("FAIL abort_start_ignored: got %b want 010", {busy12, prst12, pck12}); end
    total++; if (rise12 !== 5) begin bad++; $display("FAIL abort_rises: got %0d want 5", rise12); end
    total++; if (err12 !== 1'b0) begin bad++; $display("FAIL abort_err: got %b want 0", err12); end
    valid12 = 1'b0;
  endtask

  task automatic test_ignored;
    start_load12();
    feed12(3, 100);
    total++; if (left12 !== 4'd10) begin bad++; $display("FAIL ign_left_before: got %0d want 10", left12); end
    start12 = 1'b1;
    tick();
    start12 = 1'b0;
    total++; if (left12 !== 4'd9) begin bad++; $display("FAIL ign_left_after: got %0d want 9", left12); end
    total++; if (busy12 !== 1'b1) begin bad++; $display("FAIL ign_busy: got %b want 1", busy12); end
    feed12(0, 100);
    total++; if (seq12 !== 12'hA53) begin bad++; $display("FAIL ign_seq: got %h want a53", seq12); end
    total++; if (fab12 !== 1'b1) begin bad++; $display("FAIL ign_fab_done: got %b want 1", fab12); end
    start_load12();
    total++; if ({done12, fab12, busy12, prst12} !== 4'b0011)
      begin bad++; $display("FAIL reload_flags: got %b want 0011", {done12, fab12, busy12, prst12}); end
    total++; if (left12 !== 4'd12) begin bad++; $display("FAIL reload_left: got %0d want 12", left12); end
    feed12(0, 100);
    total++; if ({done12, fab12} !== 2'b11) begin bad++; $display("FAIL reload_done: got %b want 11", {done12, fab12}); end
    valid12 = 1'b0;
  endtask

  task automatic test_reset_clear;
    start_load12();
    feed12(3, 100);
    #2;
    rstn = 1'b0;
    #1;
    total++; if ({pck12, prst12, busy12} !== 3'b010)
      begin bad++; $display("FAIL async_rst: got %b want 010", {pck12, prst12, busy12}); end
    rstn = 1'b1;
    valid12 = 1'b0;
    tick();
    start12 = 1'b1;
    tick();
    start12 = 1'b0;
    total++; if ({prst12, ready12} !== 2'b10) begin bad++; $display("FAIL clear_c1: got %b want 10", {prst12, ready12}); end
    tick();
    total++; if ({prst12, ready12} !== 2'b10) begin bad++; $display("FAIL clear_c2: got %b want 10", {prst12, ready12}); end
    tick();
    total++; if ({prst12, ready12} !== 2'b01) begin bad++; $display("FAIL clear_t3: got %b want 01", {prst12, ready12}); end
    tick();
    total++; if (ready12 !== 1'b1) begin bad++; $display("FAIL fetch_wait: got %b want 1", ready12); end
    abort12 = 1'b1;
    tick();
    abort12 = 1'b0;
  endtask

  task automatic test_backpressure;
    logic xfer;
    int   n, bi, cyc;
    rise64 = 0;
    seq64  = '0;
    bi = 0;
    cyc = 0;
    start64 = 1'b1;
    tick();
    start64 = 1'b0;
    for (n = 0; n < 600 && !done64; n++) begin
      valid64 = (cyc % 3 == 0);
      data64  = (bi < 8) ? (valid64 ? bytes64[bi] : ~bytes64[bi]) : 8'h00;
      xfer = valid64 && ready64;
      tick();
      if (xfer) bi++;
      cyc++;
    end
    valid64 = 1'b0;
    total++; if (done64 !== 1'b1) begin bad++; $display("FAIL bp_done: got %b want 1 after %0d", done64, n); end
    total++; if (bi !== 8) begin bad++; $display("FAIL bp_xfers: got %0d want 8", bi); end
    total++; if (rise64 !== 64) begin bad++; $display("FAIL bp_rises: got %0d want 64", rise64); end
    total++; if (seq64 !== 64'hA53CF00F9669C381)
      begin bad++; $display("FAIL bp_seq: got %h want a53cf00f9669c381", seq64); end
    total++; if (chain64 !== 64'hA53CF00F9669C381)
      begin bad++; $display("FAIL bp_chain: got %h want a53cf00f9669c381", chain64); end
    total++; if ({fab64, err64} !== 2'b10) begin bad++; $display("FAIL bp_fab: got %b want 10", {fab64, err64}); end
  endtask

  initial begin
    rise12 = 0;
    rst_edge12 = 0;
    seq12 = '0;
    bi12 = 0;
    test_reset();
    test_basic();
    test_fault();
    test_abort();
    test_ignored();
    test_reset_clear();
    test_backpressure();
    total++; if (rst_edge12 !== 0)
      begin bad++; $display("FAIL ck_during_rst: got %0d edges want 0", rst_edge12); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/config_chain_loader.md
Name: config_chain_loader

Overview:
- Upstream controller for the fabric configuration chain, a serial chain of DFFR cells.
- Accepts a bitstream as bytes over a valid/ready handshake and clears the chain.
- Serialises exactly CHAIN_LEN bits into the chain using a generated programming clock, and checks the chain tail for stuck/short faults during load.
- On a clean load it asserts FABRIC_EN to release the user fabric.

Parameters:
- CHAIN_LEN, 64, number of config flops in the chain (>=1).
- CLR_CYC, 2, CK cycles PROG_RST is held high in CLEAR (>=1).

Ports:
- CK  in  1  system clock; all state updates on rising edge.
- RSTN  in  1  asynchronous, active-low reset.
- START  in  1  1-cycle request to begin a load; honoured only in IDLE or DONE.
- ABORT  in  1  level; forces the abort sequence from any state.
- IN_DATA  in  8  bitstream byte; MSB shifted first.
- IN_VALID  in  1  IN_DATA valid.
- IN_READY  out  1  loader accepts a byte this cycle.
- PROG_CK  out  1  chain clock (registered, glitch-free).
- PROG_D  out  1  chain serial data, to the head flop D.
- PROG_RST  out  1  active-high chain reset, to all chain cell RST pins.
- PROG_Q  in  1  chain tail Q.
- BUSY  out  1  high in CLEAR/FETCH/SHIFT_LO/SHIFT_HI.
- DONE  out  1  high in DONE state.
- ERR  out  1  sticky tail-fault flag.
- FABRIC_EN  out  1  high in DONE when ERR=0.
- BITS_LEFT  out  $clog2(CHAIN_LEN+1)  bits still to shift.

Behaviour:
- All outputs registered.
- RSTN low (async): state=IDLE, PROG_CK=0, PROG_D=0, PROG_RST=1, IN_READY=0, BUSY=0, DONE=0, ERR=0, FABRIC_EN=0, BITS_LEFT=0.
- IDLE: PROG_RST=1, PROG_CK=0. START -> CLEAR; BITS_LEFT<=CHAIN_LEN; ERR<=0.
- CLEAR: PROG_RST=1 for CLR_CYC cycles -> FETCH with PROG_RST=0. START at cycle t gives first IN_READY=1 at t+CLR_CYC+1.
- FETCH: IN_READY=1, PROG_CK=0.
  - Transfer when IN_VALID && IN_READY: byte latched into an 8-bit shift register, bit index=7, next state SHIFT_LO.
  - IN_VALID low: wait indefinitely with no timeout.
- SHIFT_LO, one cycle: PROG_CK=0, PROG_D=current bit. PROG_Q is sampled at the closing CK edge; a value of 1 sets ERR. After CLEAR every pre-existing chain bit must read 0 at the tail.
- SHIFT_HI, one cycle: PROG_CK=1, PROG_D held, so the chain captures on the PROG_CK rising edge. BITS_LEFT decrements at the closing edge.
  - BITS_LEFT becomes 0 -> DONE. Any unshifted LSBs of the current byte are discarded.
  - Else byte exhausted -> FETCH.
  - Else next bit -> SHIFT_LO.
- Bit rate: 2 CK per bit. One FETCH cycle minimum per byte. Byte throughput 17 CK with IN_VALID held high.
- DONE: PROG_CK=0, PROG_RST=0 (configuration retained), DONE=1, FABRIC_EN=~ERR.
  - START -> CLEAR: FABRIC_EN drops in the same cycle DONE drops.
- Handshake: IN_READY is never high outside FETCH. IN_DATA/IN_VALID are ignored otherwise.
- ABORT, which has priority over START and over handshake transfers:
  - Next state IDLE; PROG_CK=0, PROG_RST=1, FABRIC_EN=0, DONE=0, IN_READY=0.
  - ERR keeps its value until the next START.
  - Abort mid-SHIFT_HI: PROG_CK falls on the next edge and is never left high.
- START while BUSY is ignored.
- START and ABORT together: ABORT wins.
- CHAIN_LEN not a multiple of 8: the final byte uses only its top (CHAIN_LEN mod 8) bits.
- PROG_CK pulses exactly CHAIN_LEN times per load. No PROG_CK edge while PROG_RST=1.

Test Plan:
- CHAIN_LEN=12, bytes 0xA5,0x3C with IN_VALID always high:
  - PROG_D sequence at PROG_CK rises: 1,0,1,0,0,1,0,1,0,0,1,1.
  - Exactly 12 PROG_CK rises.
  - DONE=1, FABRIC_EN=1, ERR=0; chain model holds the pattern.
- Reset and CLEAR timing: RSTN low mid-SHIFT_HI -> PROG_CK=0, PROG_RST=1 immediately (async). After RSTN release, START -> PROG_RST high 2 cycles, IN_READY at t+3.
- Backpressure: IN_VALID toggling 1-in-3 cycles, CHAIN_LEN=64 -> 8 transfers only when IN_READY=1; PROG_CK/PROG_D pattern identical to the continuous case.
- Fault: chain model tail stuck-at-1 -> ERR=1 after first SHIFT_LO; load completes; DONE=1, FABRIC_EN=0. A new START clears ERR.
- ABORT in the 5th bit's SHIFT_HI -> next cycle IDLE, PROG_CK=0, PROG_RST=1, BUSY=0. START during the abort cycle is ignored.
- Ignored requests: START pulse while BUSY has no effect on BITS_LEFT. START in DONE reloads, with FABRIC_EN=0 from that cycle onward.
